// File: rtl/buffer_byte_streamer.sv
// Streams 64-bit words from an attached word buffer out as a little-endian byte stream,
// with a one-word read/load handshake per word and valid/ready flow control on the output.
module buffer_byte_streamer #(
    parameter int BuffDepth = 256,
    parameter int WordAddrW = $clog2(BuffDepth / 8)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WordAddrW-1:0] start_word,
    input  logic [WordAddrW:0]   num_words,
    output logic                 busy,
    output logic                 done,
    output logic                 buf_read_en,
    output logic                 buf_addr_mode,
    output logic [WordAddrW-1:0] buf_word_addr,
    input  logic [63:0]          buf_word_in,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [7:0]           m_data,
    output logic                 m_last
);

    localparam int                   NumWords = BuffDepth / 8;
    localparam logic [WordAddrW-1:0] LastAddr = WordAddrW'(NumWords - 1);
    localparam logic [WordAddrW-1:0] AddrStep = 1;
    localparam logic [WordAddrW:0]   CntStep  = 1;
    localparam logic [2:0]           LastByte = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD,
        SEND,
        DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [WordAddrW-1:0] addr;
    logic [WordAddrW:0]   words_left;
    logic [63:0]          shreg;
    logic [2:0]           byte_idx;
    logic                 final_word;

    assign buf_addr_mode = 1'b1;
    assign buf_word_addr = addr;
    assign final_word    = (words_left == CntStep);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        busy        = 1'b1;
        done        = 1'b0;
        buf_read_en = 1'b0;
        m_valid     = 1'b0;
        m_data      = 8'h00;
        m_last      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (num_words == '0) ? DONE : READ;
                end
            end
            READ: begin
                buf_read_en = 1'b1;
                state_nxt   = LOAD;
            end
            LOAD: begin
                state_nxt = SEND;
            end
            SEND: begin
                m_valid = 1'b1;
                m_data  = shreg[7:0];
                m_last  = (byte_idx == LastByte) && final_word;
                if (m_ready && (byte_idx == LastByte)) begin
                    state_nxt = final_word ? DONE : READ;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The word is shifted right one byte per accepted transfer, so the
    // current byte always sits in bits 7:0 and stays put while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr       <= '0;
            words_left <= '0;
            shreg      <= '0;
            byte_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (num_words != '0)) begin
                        addr       <= start_word;
                        words_left <= num_words;
                    end
                end
                LOAD: begin
                    shreg    <= buf_word_in;
                    byte_idx <= '0;
                end
                SEND: begin
                    if (m_ready) begin
                        shreg    <= {8'h00, shreg[63:8]};
                        byte_idx <= byte_idx + 3'd1;
                        if (byte_idx == LastByte) begin
                            words_left <= words_left - CntStep;
                            addr       <= (addr == LastAddr) ? '0 : addr + AddrStep;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_byte_streamer.sv
// Bench for buffer_byte_streamer: a queue-based model of the expected byte stream and
// read addresses is compared every cycle, plus directed timing and boundary checks.
module tb_buffer_byte_streamer;

    localparam int AW = 5;
    localparam int NW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_word;
    logic [AW:0]   num_words;
    logic          busy;
    logic          done;
    logic          buf_read_en;
    logic          buf_addr_mode;
    logic [AW-1:0] buf_word_addr;
    logic [63:0]   buf_word_in;
    logic          m_valid;
    logic          m_ready;
    logic [7:0]    m_data;
    logic          m_last;

    buffer_byte_streamer #(.BuffDepth(256)) dut (
        .clk(clk), .rst(rst), .start(start), .start_word(start_word), .num_words(num_words),
        .busy(busy), .done(done), .buf_read_en(buf_read_en), .buf_addr_mode(buf_addr_mode),
        .buf_word_addr(buf_word_addr), .buf_word_in(buf_word_in), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int ready_mode = 0;

    logic [63:0] mem [NW];
    logic [8:0]  exp_q [$];
    int          addr_q [$];
    logic [7:0]  got_q [$];
    int          rd_log [$];
    int          first_vld = -1;
    int          done_cyc = -1;
    int          done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer: registered word read, garbage on the bus when not reading.
    always @(posedge clk) buf_word_in <= buf_read_en ? mem[buf_word_addr] : {$urandom, $urandom};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bad(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Per-cycle compare against the model queues.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        logic       prev_done;
        logic [8:0] e;
        prev_stall = 1'b0;
        prev_done  = 1'b0;
        prev_data  = 8'h00;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                prev_done  = 1'b0;
            end else begin
                chk("addr_mode", 64'(buf_addr_mode), 64'd1);
                if (m_valid && first_vld < 0) first_vld = cyc;
                if (buf_read_en) begin
                    rd_log.push_back(int'(buf_word_addr));
                    chk("valid_in_read", 64'(m_valid), 64'd0);
                    if (addr_q.size() == 0) bad("unexpected_read");
                    else chk("read_addr", 64'(buf_word_addr), 64'(addr_q.pop_front()));
                end
                if (prev_stall) begin
                    chk("stall_valid", 64'(m_valid), 64'd1);
                    chk("stall_data", 64'(m_data), 64'(prev_data));
                    chk("stall_last", 64'(m_last), 64'(prev_last));
                end
                if (m_valid && m_ready) begin
                    got_q.push_back(m_data);
                    if (exp_q.size() == 0) bad("unexpected_byte");
                    else begin
                        e = exp_q.pop_front();
                        chk("byte", 64'(m_data), 64'(e[7:0]));
                        chk("last", 64'(m_last), 64'(e[8]));
                    end
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    chk("done_bytes_left", 64'(exp_q.size()), 64'd0);
                    chk("done_reads_left", 64'(addr_q.size()), 64'd0);
                    chk("done_one_cycle", 64'(prev_done), 64'd0);
                    chk("done_no_valid", 64'(m_valid), 64'd0);
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
                prev_done  = done;
            end
        end
    end

    task automatic load_model(input int sw, input int nw);
        int a;
        for (int w = 0; w < nw; w++) begin
            a = (sw + w) % NW;
            addr_q.push_back(a);
            for (int b = 0; b < 8; b++)
                exp_q.push_back({(w == nw - 1) && (b == 7), mem[a][8*b +: 8]});
        end
    endtask

    task automatic launch(input int sw, input int nw, output int t);
        @(posedge clk);
        #1;
        got_q.delete();
        rd_log.delete();
        first_vld  = -1;
        done_cyc   = -1;
        load_model(sw, nw);
        start      = 1'b1;
        start_word = AW'(sw);
        num_words  = (AW + 1)'(nw);
        t          = cyc;
        @(posedge clk);
        #1;
        start      = 1'b0;
        start_word = AW'($urandom);
        num_words  = (AW + 1)'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cyc < 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("done_seen", 64'(done_cyc >= 0), 64'd1);
        @(negedge clk);
        #1;
        chk("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_read_en"}, 64'(buf_read_en), 64'd0);
        chk({tag, "_valid"}, 64'(m_valid), 64'd0);
        chk({tag, "_last"}, 64'(m_last), 64'd0);
        chk({tag, "_data"}, 64'(m_data), 64'd0);
    endtask

    initial begin
        int t;
        int sw;
        int nw;
        int dc0;
        m_ready    = 1'b1;
        rst        = 1'b1;
        start      = 1'b0;
        start_word = '0;
        num_words  = '0;
        for (int i = 0; i < NW; i++) mem[i] = {$urandom, $urandom};
        mem[3] = 64'h8877665544332211;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk_idle_outputs("reset");

        // Single word, full ready: exact timing and byte order.
        launch(3, 1, t);
        wait_done(200);
        chk("w3_first_valid_cyc", 64'(first_vld), 64'(t + 3));
        chk("w3_done_cyc", 64'(done_cyc), 64'(t + 11));
        chk("w3_reads", 64'(rd_log.size()), 64'd1);
        chk("w3_read_addr", 64'(rd_log[0]), 64'd3);
        chk("w3_bytes", 64'(got_q.size()), 64'd8);
        chk("w3_byte0", 64'(got_q[0]), 64'h11);
        chk("w3_byte7", 64'(got_q[7]), 64'h88);

        // Address wrap 31 -> 0.
        launch(31, 2, t);
        wait_done(200);
        chk("wrap_reads", 64'(rd_log.size()), 64'd2);
        chk("wrap_addr0", 64'(rd_log[0]), 64'd31);
        chk("wrap_addr1", 64'(rd_log[1]), 64'd0);
        chk("wrap_bytes", 64'(got_q.size()), 64'd16);
        chk("wrap_done_cyc", 64'(done_cyc), 64'(t + 21));

        // Zero-length transfer.
        launch(7, 0, t);
        wait_done(50);
        chk("zero_done_cyc", 64'(done_cyc), 64'(t + 1));
        chk("zero_reads", 64'(rd_log.size()), 64'd0);
        chk("zero_no_valid", 64'(first_vld), 64'hFFFF_FFFF_FFFF_FFFF);

        // Alternating ready.
        ready_mode = 1;
        launch(3, 1, t);
        wait_done(400);
        chk("toggle_bytes", 64'(got_q.size()), 64'd8);
        chk("toggle_byte0", 64'(got_q[0]), 64'h11);
        ready_mode = 0;

        // Reset on the 4th byte of a 2-word transfer.
        launch(5, 2, t);
        for (int i = 0; i < 60 && got_q.size() < 3; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        addr_q.delete();
        chk("abort_bytes_before", 64'(got_q.size()), 64'd3);
        chk_idle_outputs("abort");
        repeat (25) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(done_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        launch(3, 1, t);
        wait_done(200);
        chk("after_abort_bytes", 64'(got_q.size()), 64'd8);
        chk("after_abort_byte0", 64'(got_q[0]), 64'h11);
        chk("after_abort_done_cyc", 64'(done_cyc), 64'(t + 11));

        // Start pulsed while busy is ignored.
        launch(10, 2, t);
        repeat (5) @(posedge clk);
        #1;
        start      = 1'b1;
        start_word = 5'd1;
        num_words  = 6'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(300);
        chk("restart_bytes", 64'(got_q.size()), 64'd16);
        chk("restart_done_cyc", 64'(done_cyc), 64'(t + 21));
        chk("restart_reads", 64'(rd_log.size()), 64'd2);
        chk("restart_addr1", 64'(rd_log[1]), 64'd11);

        // Randomized transfers, including lengths past the buffer size.
        for (int i = 0; i < 15; i++) begin
            ready_mode = $urandom_range(0, 2);
            sw  = $urandom_range(0, NW - 1);
            nw  = (i % 5 == 0) ? 0 : $urandom_range(1, 40);
            dc0 = done_cnt;
            launch(sw, nw, t);
            wait_done(45 * nw + 60);
            chk("rand_bytes", 64'(got_q.size()), 64'(8 * nw));
            chk("rand_done_count", 64'(done_cnt - dc0), 64'd1);
            if (ready_mode == 0) chk("rand_done_cyc", 64'(done_cyc), 64'(t + 10 * nw + 1));
        end
        ready_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/buffer_byte_streamer.md
BUFFER_BYTE_STREAMER -- requirements
Module: buffer_byte_streamer

Interface
REQ-001 Parameter BuffDepth, default 256: byte depth of the attached 64-bit word buffer.
REQ-002 Parameter WordAddrW, default $clog2(BuffDepth/8): word address width (5 at default).
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request pulse; sampled in IDLE only.
REQ-006 start_word  input  WordAddrW  first word address of the transfer.
REQ-007 num_words  input  WordAddrW+1  number of 64-bit words to stream; 0 is legal.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse when a transfer completes.
REQ-010 buf_read_en  output  1  word read strobe to the buffer.
REQ-011 buf_addr_mode  output  1  constant 1 (word mode).
REQ-012 buf_word_addr  output  WordAddrW  word address presented with buf_read_en.
REQ-013 buf_word_in  input  64  buffer read data, valid the cycle after buf_read_en.
REQ-014 m_valid  output  1  output byte valid.
REQ-015 m_ready  input  1  downstream accept.
REQ-016 m_data  output  8  output byte.
REQ-017 m_last  output  1  marks the final byte of the transfer.

Function
REQ-018 The block SHALL implement FSM states IDLE, READ, LOAD, SEND and DONE.
REQ-019 IDLE with start=1 and num_words!=0 SHALL latch start_word and num_words, then go to READ.
REQ-020 IDLE with start=1 and num_words=0 SHALL go to DONE with no buffer read.
REQ-021 READ SHALL hold buf_read_en=1 for exactly one cycle with buf_word_addr = current address, then go to LOAD.
REQ-022 buf_read_en SHALL be 0 in all states other than READ; the block never writes the buffer.
REQ-023 LOAD SHALL capture buf_word_in into a 64-bit shift register, clear the byte index to 0, and go to SEND.
REQ-024 SEND SHALL drive m_valid=1 with m_data = byte[index], little-endian (byte 0 = bits 7:0 first).
REQ-025 A byte SHALL transfer only on a cycle where m_valid=1 and m_ready=1; the index then increments.
REQ-026 While m_valid=1 and m_ready=0, m_data and m_last SHALL hold stable.
REQ-027 m_last SHALL be 1 only on byte index 7 of the final word.
REQ-028 On transfer of byte 7, the word counter SHALL decrement and the address SHALL increment modulo BuffDepth/8, wrapping 31->0 at default.
REQ-029 After byte 7, the FSM SHALL go to READ if words remain, otherwise to DONE.
REQ-030 DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-031 Latency at full ready: start at cycle T -> buf_read_en at T+1 -> first m_valid at T+3.
REQ-032 Each subsequent word SHALL add 3 cycles (READ, LOAD, first SEND) before its first byte.
REQ-033 Total cycles for N words at m_ready=1 SHALL be 10N+1 from start to done, inclusive of the done cycle.
REQ-034 start while busy=1 SHALL be ignored with no effect on the transfer in progress.
REQ-035 num_words greater than BuffDepth/8 SHALL be legal; addresses wrap and words are re-read.
REQ-036 m_valid SHALL be 0 in IDLE, READ, LOAD and DONE.

Reset
REQ-037 rst=1 SHALL force IDLE and clear busy, done, buf_read_en, m_valid, m_last, m_data, the address, the counter and the shift register to 0 on the next edge.
REQ-038 Reset asserted mid-transfer SHALL abort the transfer with no done pulse.
REQ-039 After reset, the first start SHALL behave as from power-up.

Verification
REQ-040 Buffer word[3]=64'h8877665544332211, start_word=3, num_words=1, m_ready=1 -> bytes 11,22,...,88 on cycles T+3..T+10; m_last only on 88; done at T+11.
REQ-041 start_word=31, num_words=2 -> buf_word_addr 31 then 0; 16 bytes out; m_last on the 16th byte.
REQ-042 num_words=0 -> done pulse at T+1; buf_read_en and m_valid never asserted.
REQ-043 m_ready toggled 0/1 every cycle -> same 8-byte sequence, m_data stable during stalls, no byte dropped or duplicated.
REQ-044 rst at the 4th byte of a 2-word transfer -> all outputs 0 next cycle, no done; a new start with num_words=1 then streams correctly.
REQ-045 start pulsed again mid-transfer -> ignored; byte count and done timing unchanged.
